// File: rtl/mc_controller_if.sv
// Memory request/ready handshake between the multicycle controller (master)
// and the memory port (slave).
interface mc_controller_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter enabled by defining MC_CTRL_INSTRET_EN.
module mc_controller (
    input  logic                   clk,
    input  logic                   n_reset,
    mc_controller_if.master        mem,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic                   funct7b5,
    input  logic                   alu_zero,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic                   pc_src,
    output logic                   rf_we,
    output logic [1:0]             result_sel,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [3:0]             alu_op,
    output logic [3:0]             state,
    output logic                   illegal,
    output logic [31:0]            instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8, ALU_SLTU = 4'd9;

    // funct7b5 selects sub only for R-type; it selects sra for both R and I shifts
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic        mem_req_s, mem_we_s, addr_sel_s, ir_we_s, pc_we_s, pc_src_s, rf_we_s, illegal_s;
    logic [1:0]  result_sel_s, alu_src_a_s, alu_src_b_s;
    logic [3:0]  alu_op_s;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt_s  = state_r;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        addr_sel_s   = 1'b0;
        ir_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        pc_src_s     = 1'b0;
        rf_we_s      = 1'b0;
        illegal_s    = 1'b0;
        result_sel_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = ALU_ADD;
        if (!n_reset) begin
            // FETCH datapath settings with every strobe held off
            state_nxt_s = S_FETCH;
            alu_src_b_s = 2'b10;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_req_s   = 1'b1;
                    alu_src_b_s = 2'b10;
                    ir_we_s     = mem.mem_ready;
                    pc_we_s     = mem.mem_ready;
                    state_nxt_s = mem.mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a_s = 2'b01;
                    alu_src_b_s = 2'b01;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_nxt_s = S_MEMADR;
                        OP_R:              state_nxt_s = S_EXEC_R;
                        OP_I:              state_nxt_s = S_EXEC_I;
                        OP_BRANCH:         state_nxt_s = S_BRANCH;
                        OP_JAL:            state_nxt_s = S_JAL;
                        default:           state_nxt_s = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a_s = 2'b10;
                    alu_src_b_s = 2'b01;
                    state_nxt_s = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req_s   = 1'b1;
                    addr_sel_s  = 1'b1;
                    state_nxt_s = mem.mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    rf_we_s      = 1'b1;
                    result_sel_s = 2'b01;
                    state_nxt_s  = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b1;
                    addr_sel_s  = 1'b1;
                    state_nxt_s = mem.mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC_R, S_EXEC_I: begin
                    alu_src_a_s = 2'b10;
                    alu_src_b_s = (state_r == S_EXEC_R) ? 2'b00 : 2'b01;
                    alu_op_s    = alu_decode(funct3, funct7b5, state_r == S_EXEC_R);
                    state_nxt_s = S_ALUWB;
                end
                S_ALUWB: begin
                    rf_we_s     = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a_s = 2'b10;
                    alu_op_s    = ALU_SUB;
                    pc_src_s    = 1'b1;
                    pc_we_s     = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);
                    state_nxt_s = S_FETCH;
                end
                S_JAL: begin
                    alu_src_a_s  = 2'b01;
                    alu_src_b_s  = 2'b10;
                    rf_we_s      = 1'b1;
                    result_sel_s = 2'b10;
                    pc_we_s      = 1'b1;
                    pc_src_s     = 1'b1;
                    state_nxt_s  = S_FETCH;
                end
                S_TRAP: begin
                    illegal_s   = 1'b1;
                    state_nxt_s = S_TRAP;
                end
                default: begin
                    state_nxt_s = S_TRAP;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_s;
    assign mem.mem_we   = mem_we_s;
    assign mem.addr_sel = addr_sel_s;
    assign ir_we        = ir_we_s;
    assign pc_we        = pc_we_s;
    assign pc_src       = pc_src_s;
    assign rf_we        = rf_we_s;
    assign result_sel   = result_sel_s;
    assign alu_src_a    = alu_src_a_s;
    assign alu_src_b    = alu_src_b_s;
    assign alu_op       = alu_op_s;
    assign illegal      = illegal_s;
    assign state        = state_r;

`ifdef MC_CTRL_INSTRET_EN
    logic [31:0] instret_r;
    logic        retire_s;

    // An instruction retires on the cycle it hands control back to FETCH
    always_comb begin
        retire_s = 1'b0;
        if (!n_reset) begin
            retire_s = 1'b0;
        end else begin
            case (state_r)
                S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: retire_s = 1'b1;
                S_MEMWR:                           retire_s = mem.mem_ready;
                default:                           retire_s = 1'b0;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            instret_r <= 32'h0;
        end else if (retire_s) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle stimulus and expected
// outputs are queued per scenario, then driven and compared cycle by cycle.
module tb_mc_controller;

`ifdef MC_CTRL_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5, alu_zero;
    logic        ir_we, pc_we, pc_src, rf_we, illegal;
    logic [1:0]  result_sel, alu_src_a, alu_src_b;
    logic [3:0]  alu_op, state;
    logic [31:0] instret;

    mc_controller_if mem_bus ();

    mc_controller dut (
        .clk(clk), .n_reset(n_reset), .mem(mem_bus), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .alu_zero(alu_zero), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .rf_we(rf_we), .result_sel(result_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        rdy;
        logic        z;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [21:0] exp;
        logic [21:0] msk;
    } step_t;

    step_t       sb[$];
    step_t       cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned retired = 0;
    logic [21:0] got;

    localparam logic [21:0] FULL = 22'h3FFFFF;
    localparam logic [21:0] NOST = 22'h03FFFE;   // ignore state and illegal

    // strb order: mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we
    function automatic logic [21:0] ev(input logic [3:0] st, input logic [6:0] strb, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b, input logic [3:0] op,
                                       input logic ill);
        return {st, strb, rs, a, b, op, ill};
    endfunction

    logic [21:0] V_FW, V_FR, V_RST, V_DEC, V_MA, V_MR, V_MWB, V_MW, V_AWB, V_JAL, V_TRAP;

    task automatic push(input string nm, input logic r, input logic rdy, input logic z,
                        input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [21:0] e, input logic [21:0] m);
        step_t s;
        s.name = nm; s.rst = r; s.rdy = rdy; s.z = z; s.opc = opc; s.f3 = f3; s.f7 = f7;
        s.exp = e; s.msk = m;
        sb.push_back(s);
    endtask

    task automatic apply(input step_t s);
        n_reset = s.rst; mem_bus.mem_ready = s.rdy; alu_zero = s.z;
        opcode = s.opc; funct3 = s.f3; funct7b5 = s.f7;
    endtask

    function automatic logic [21:0] sample();
        return {state, mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel, ir_we, pc_we, pc_src,
                rf_we, result_sel, alu_src_a, alu_src_b, alu_op, illegal};
    endfunction

    task automatic test_reset();
        push("rst0", 1'b0, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_RST, NOST);
        push("rst1", 1'b0, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_RST, FULL);
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
        retired = 0;
        n_cmp++;
        if (instret !== 32'h0) begin n_bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
    endtask

    task automatic test_addi();
        push("addi_f", 1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_FR, FULL);
        push("addi_d", 1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_DEC, FULL);
        push("addi_x", 1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, ev(4'd7, 7'd0, 2'b00, 2'b10, 2'b01, 4'h0, 1'b0), FULL);
        push("addi_w", 1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_AWB, FULL);
        retired++;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== (INSTRET_ON ? retired : 32'd0)) begin
            n_bad++; $display("FAIL addi_instret: got %0d want %0d", instret, INSTRET_ON ? retired : 32'd0);
        end
    endtask

    task automatic test_alu_ops();
        // {is_r, funct3, funct7b5, expected alu_op}
        logic [8:0] tbl [6] = '{{1'b1, 3'b000, 1'b1, 4'h1}, {1'b0, 3'b101, 1'b1, 4'h8},
                                {1'b0, 3'b000, 1'b1, 4'h0}, {1'b1, 3'b001, 1'b0, 4'h6},
                                {1'b0, 3'b011, 1'b0, 4'h9}, {1'b1, 3'b110, 1'b0, 4'h3}};
        for (int i = 0; i < 6; i++) begin
            logic [6:0] opc;
            opc = tbl[i][8] ? 7'h33 : 7'h13;
            push("alu_f", 1'b1, 1'b1, 1'b0, opc, tbl[i][7:5], tbl[i][4], V_FR, FULL);
            push("alu_d", 1'b1, 1'b1, 1'b0, opc, tbl[i][7:5], tbl[i][4], V_DEC, FULL);
            push("alu_x", 1'b1, 1'b1, 1'b0, opc, tbl[i][7:5], tbl[i][4],
                 ev(tbl[i][8] ? 4'd6 : 4'd7, 7'd0, 2'b00, 2'b10, tbl[i][8] ? 2'b00 : 2'b01, tbl[i][3:0], 1'b0), FULL);
            push("alu_w", 1'b1, 1'b1, 1'b0, opc, tbl[i][7:5], tbl[i][4], V_AWB, FULL);
            retired++;
        end
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        push("lw_f", 1'b1, 1'b1, 1'b0, 7'h03, 3'd2, 1'b0, V_FR, FULL);
        push("lw_d", 1'b1, 1'b1, 1'b0, 7'h03, 3'd2, 1'b0, V_DEC, FULL);
        push("lw_a", 1'b1, 1'b1, 1'b0, 7'h03, 3'd2, 1'b0, V_MA, FULL);
        for (int i = 0; i < 3; i++) push("lw_wait", 1'b1, 1'b0, 1'b0, 7'h03, 3'd2, 1'b0, V_MR, FULL);
        push("lw_rdy", 1'b1, 1'b1, 1'b0, 7'h03, 3'd2, 1'b0, V_MR, FULL);
        push("lw_wb", 1'b1, 1'b0, 1'b0, 7'h03, 3'd2, 1'b0, V_MWB, FULL);
        retired++;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (state !== 4'd0) begin n_bad++; $display("FAIL lw_done: got state %0d want 0", state); end
    endtask

    task automatic test_branch();
        // {funct3, alu_zero, expected pc_we}
        logic [4:0] tbl [4] = '{{3'b000, 1'b1, 1'b1}, {3'b001, 1'b1, 1'b0},
                                {3'b001, 1'b0, 1'b1}, {3'b100, 1'b1, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            push("br_f", 1'b1, 1'b1, tbl[i][1], 7'h63, tbl[i][4:2], 1'b0, V_FR, FULL);
            push("br_d", 1'b1, 1'b1, tbl[i][1], 7'h63, tbl[i][4:2], 1'b0, V_DEC, FULL);
            push("br_x", 1'b1, 1'b1, tbl[i][1], 7'h63, tbl[i][4:2], 1'b0,
                 ev(4'd9, tbl[i][0] ? 7'b0000110 : 7'b0000010, 2'b00, 2'b10, 2'b00, 4'h1, 1'b0), FULL);
            retired++;
        end
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== (INSTRET_ON ? retired : 32'd0)) begin
            n_bad++; $display("FAIL br_instret: got %0d want %0d", instret, INSTRET_ON ? retired : 32'd0);
        end
    endtask

    task automatic test_back_to_back();
        push("sw_fw", 1'b1, 1'b0, 1'b0, 7'h23, 3'd2, 1'b0, V_FW, FULL);
        push("sw_fw", 1'b1, 1'b0, 1'b0, 7'h23, 3'd2, 1'b0, V_FW, FULL);
        push("sw_f",  1'b1, 1'b1, 1'b0, 7'h23, 3'd2, 1'b0, V_FR, FULL);
        push("sw_d",  1'b1, 1'b1, 1'b0, 7'h23, 3'd2, 1'b0, V_DEC, FULL);
        push("sw_a",  1'b1, 1'b1, 1'b0, 7'h23, 3'd2, 1'b0, V_MA, FULL);
        push("sw_w",  1'b1, 1'b1, 1'b0, 7'h23, 3'd2, 1'b0, V_MW, FULL);
        push("jal_f", 1'b1, 1'b1, 1'b0, 7'h6F, 3'd0, 1'b0, V_FR, FULL);
        push("jal_d", 1'b1, 1'b1, 1'b0, 7'h6F, 3'd0, 1'b0, V_DEC, FULL);
        push("jal_x", 1'b1, 1'b1, 1'b0, 7'h6F, 3'd0, 1'b0, V_JAL, FULL);
        retired += 2;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== (INSTRET_ON ? retired : 32'd0)) begin
            n_bad++; $display("FAIL b2b_instret: got %0d want %0d", instret, INSTRET_ON ? retired : 32'd0);
        end
    endtask

    task automatic test_trap();
        push("trap_f", 1'b1, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, V_FR, FULL);
        push("trap_d", 1'b1, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, V_DEC, FULL);
        for (int i = 0; i < 10; i++) push("trap_hold", 1'b1, i[0], i[1], 7'h7F, 3'd0, 1'b0, V_TRAP, FULL);
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== (INSTRET_ON ? retired : 32'd0)) begin
            n_bad++; $display("FAIL trap_instret: got %0d want %0d", instret, INSTRET_ON ? retired : 32'd0);
        end
        push("trap_rst", 1'b0, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, V_RST, NOST);
        push("trap_out", 1'b1, 1'b0, 1'b0, 7'h13, 3'd0, 1'b0, V_FW, FULL);
        retired = 0;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_reset();
        push("fr_wait", 1'b1, 1'b0, 1'b0, 7'h13, 3'd0, 1'b0, V_FW, FULL);
        push("fr_rst",  1'b0, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_RST, FULL);
        push("fr_re1",  1'b1, 1'b0, 1'b0, 7'h13, 3'd0, 1'b0, V_FW, FULL);
        push("fr_re2",  1'b1, 1'b0, 1'b0, 7'h13, 3'd0, 1'b0, V_FW, FULL);
        push("fr_rdy",  1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_FR, FULL);
        push("fr_d",    1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_DEC, FULL);
        push("fr_x",    1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, ev(4'd7, 7'd0, 2'b00, 2'b10, 2'b01, 4'h0, 1'b0), FULL);
        push("fr_w",    1'b1, 1'b1, 1'b0, 7'h13, 3'd0, 1'b0, V_AWB, FULL);
        retired = 1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); apply(cur); @(negedge clk); got = sample(); n_cmp++;
            if ((got & cur.msk) !== (cur.exp & cur.msk)) begin
                n_bad++; $display("FAIL %s: got %h want %h", cur.name, got & cur.msk, cur.exp & cur.msk);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (instret !== (INSTRET_ON ? retired : 32'd0)) begin
            n_bad++; $display("FAIL fr_instret: got %0d want %0d", instret, INSTRET_ON ? retired : 32'd0);
        end
    endtask

    initial begin
        V_FW   = ev(4'd0,  7'b1000000, 2'b00, 2'b00, 2'b10, 4'h0, 1'b0);
        V_FR   = ev(4'd0,  7'b1001100, 2'b00, 2'b00, 2'b10, 4'h0, 1'b0);
        V_RST  = ev(4'd0,  7'b0000000, 2'b00, 2'b00, 2'b10, 4'h0, 1'b0);
        V_DEC  = ev(4'd1,  7'b0000000, 2'b00, 2'b01, 2'b01, 4'h0, 1'b0);
        V_MA   = ev(4'd2,  7'b0000000, 2'b00, 2'b10, 2'b01, 4'h0, 1'b0);
        V_MR   = ev(4'd3,  7'b1010000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
        V_MWB  = ev(4'd4,  7'b0000001, 2'b01, 2'b00, 2'b00, 4'h0, 1'b0);
        V_MW   = ev(4'd5,  7'b1110000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
        V_AWB  = ev(4'd8,  7'b0000001, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
        V_JAL  = ev(4'd10, 7'b0000111, 2'b10, 2'b01, 2'b10, 4'h0, 1'b0);
        V_TRAP = ev(4'd11, 7'b0000000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b1);
        n_reset = 1'b0; mem_bus.mem_ready = 1'b0; alu_zero = 1'b0;
        opcode = 7'h13; funct3 = 3'd0; funct7b5 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_addi();
        test_alu_ops();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_trap();
        test_fetch_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
